// File: rtl/datapath_param.sv
// Parametrised multicycle ARM-subset datapath: register file, ALU, memory interface
// registers and an iterative shift-add multiplier with a start/busy/done handshake.
module datapath_param #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16,
   parameter int RA_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] Adr,
   output logic [WIDTH-1:0] WriteData,
   input  logic [WIDTH-1:0] ReadData,
   output logic [WIDTH-1:0] Instr,
   output logic [3:0]       ALUFlags,
   input  logic             PCWrite,
   input  logic             RegWrite,
   input  logic             IRWrite,
   input  logic             AdrSrc,
   input  logic [1:0]       RegSrc,
   input  logic [1:0]       ALUSrcA,
   input  logic [1:0]       ALUSrcB,
   input  logic [1:0]       ResultSrc,
   input  logic [1:0]       ImmSrc,
   input  logic [2:0]       ALUControl,
   input  logic             MulStart,
   output logic             MulBusy,
   output logic             MulDone
);

   // state    | meaning
   // MUL_IDLE | waiting for MulStart
   // MUL_RUN  | one shift-add step per cycle, WIDTH steps
   // MUL_DONE | MulOut loaded, MulDone high for this cycle
   typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;

   localparam int              CNT_W  = $clog2(WIDTH);
   localparam logic [RA_W-1:0] PC_IDX = RA_W'(NREGS - 1);

   logic [WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, data_q, a_q, wd_q, alu_out_q;
   logic [WIDTH-1:0] mul_out_q, mul_out_d, mcand_q, mcand_d, mplr_q, mplr_d, acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mul_state_t       mul_state_q, mul_state_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic [WIDTH-1:0] rf_q [NREGS];
   logic [23:0]      instr_lo;
   logic [RA_W-1:0]  ra1, ra2, wa;
   logic [WIDTH-1:0] rd1, rd2, ext_imm, src_a, src_b, b_eff, alu_result, result;
   logic [WIDTH:0]   sum;
   logic             is_sub, flag_c, flag_v;

   // Narrow widths zero-extend, wide widths drop bits above the branch offset field.
   assign instr_lo = 24'(instr_q);
   assign ra1 = RegSrc[0] ? PC_IDX : instr_lo[16 +: RA_W];
   assign ra2 = RegSrc[1] ? instr_lo[12 +: RA_W] : instr_lo[0 +: RA_W];
   assign wa  = instr_lo[12 +: RA_W];
   assign rd1 = (ra1 == PC_IDX) ? result : rf_q[ra1];
   assign rd2 = (ra2 == PC_IDX) ? result : rf_q[ra2];

   always_comb begin
      ext_imm = '0;
      case (ImmSrc)
         2'b00:   ext_imm = WIDTH'(instr_lo[7:0]);
         2'b01:   ext_imm = WIDTH'(instr_lo[11:0]);
         2'b10:   ext_imm = WIDTH'($signed({instr_lo, 2'b00}));
         default: ext_imm = '0;
      endcase
   end

   always_comb begin
      src_a = '0;
      case (ALUSrcA)
         2'b00:   src_a = a_q;
         2'b01:   src_a = pc_q;
         2'b10:   src_a = alu_out_q;
         default: src_a = '0;
      endcase
      src_b = '0;
      case (ALUSrcB)
         2'b00:   src_b = wd_q;
         2'b01:   src_b = ext_imm;
         2'b10:   src_b = WIDTH'(WIDTH / 8);
         default: src_b = '0;
      endcase
   end

   // SUB is A + ~B + 1 so the carry out reads as "no borrow".
   assign is_sub = (ALUControl == 3'b001);
   assign b_eff  = is_sub ? ~src_b : src_b;
   assign sum    = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

   always_comb begin
      alu_result = '0;
      flag_c     = 1'b0;
      flag_v     = 1'b0;
      case (ALUControl)
         3'b000, 3'b001: begin
            alu_result = sum[WIDTH-1:0];
            flag_c     = sum[WIDTH];
            flag_v     = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b100:  alu_result = src_a ^ src_b;
         3'b101:  alu_result = src_b;
         default: alu_result = '0;
      endcase
   end

   assign ALUFlags = {alu_result[WIDTH-1], alu_result == '0, flag_c, flag_v};

   always_comb begin
      result = alu_out_q;
      case (ResultSrc)
         2'b00:   result = alu_out_q;
         2'b01:   result = data_q;
         2'b10:   result = alu_result;
         default: result = mul_out_q;
      endcase
   end

   assign pc_d    = PCWrite ? result : pc_q;
   assign instr_d = IRWrite ? ReadData : instr_q;

   always_comb begin
      mul_state_d = mul_state_q;
      mcand_d     = mcand_q;
      mplr_d      = mplr_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      mul_out_d   = mul_out_q;
      case (mul_state_q)
         MUL_IDLE: if (MulStart) begin
            mcand_d     = a_q;
            mplr_d      = wd_q;
            acc_d       = '0;
            cnt_d       = '0;
            mul_state_d = MUL_RUN;
         end
         MUL_RUN: begin
            acc_d   = mplr_q[0] ? acc_q + mcand_q : acc_q;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               mul_out_d   = acc_d;
               mul_state_d = MUL_DONE;
            end
         end
         MUL_DONE: mul_state_d = MUL_IDLE;
         default:  mul_state_d = MUL_IDLE;
      endcase
      busy_d = (mul_state_d != MUL_IDLE);
      done_d = (mul_state_d == MUL_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= '0;
         instr_q     <= '0;
         data_q      <= '0;
         a_q         <= '0;
         wd_q        <= '0;
         alu_out_q   <= '0;
         mul_out_q   <= '0;
         mcand_q     <= '0;
         mplr_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         mul_state_q <= MUL_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         data_q      <= ReadData;
         a_q         <= rd1;
         wd_q        <= rd2;
         alu_out_q   <= alu_result;
         mul_out_q   <= mul_out_d;
         mcand_q     <= mcand_d;
         mplr_q      <= mplr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         mul_state_q <= mul_state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // The PC slot of the file is never written; the PC lives in pc_q.
   always_ff @(posedge clk) begin
      if (!reset && RegWrite && (wa != PC_IDX))
         rf_q[wa] <= result;
   end

   assign Adr       = AdrSrc ? alu_out_q : pc_q;
   assign WriteData = wd_q;
   assign Instr     = instr_q;
   assign MulBusy   = busy_q;
   assign MulDone   = done_q;

endmodule

// File: tb/tb_datapath_param.sv
// Bench for datapath_param: random ALU/immediate/multiply traffic against an arithmetic
// reference, plus a 16-bit, 8-register instance for PC step and multiply width.
module tb_datapath_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, PCWrite, RegWrite, IRWrite, AdrSrc, MulStart, MulBusy, MulDone;
   logic [31:0] Adr, WriteData, ReadData, Instr;
   logic [3:0]  ALUFlags;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUControl;

   logic        s_reset, s_PCWrite, s_RegWrite, s_IRWrite, s_AdrSrc, s_MulStart, s_MulBusy, s_MulDone;
   logic [15:0] s_Adr, s_WriteData, s_ReadData, s_Instr;
   logic [3:0]  s_ALUFlags;
   logic [1:0]  s_RegSrc, s_ALUSrcA, s_ALUSrcB, s_ResultSrc, s_ImmSrc;
   logic [2:0]  s_ALUControl;

   datapath_param #(.WIDTH(32), .NREGS(16), .RA_W(4)) dut (
      .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
      .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone));

   datapath_param #(.WIDTH(16), .NREGS(8), .RA_W(3)) dut_s (
      .clk(clk), .reset(s_reset), .Adr(s_Adr), .WriteData(s_WriteData), .ReadData(s_ReadData),
      .Instr(s_Instr), .ALUFlags(s_ALUFlags), .PCWrite(s_PCWrite), .RegWrite(s_RegWrite),
      .IRWrite(s_IRWrite), .AdrSrc(s_AdrSrc), .RegSrc(s_RegSrc), .ALUSrcA(s_ALUSrcA),
      .ALUSrcB(s_ALUSrcB), .ResultSrc(s_ResultSrc), .ImmSrc(s_ImmSrc), .ALUControl(s_ALUControl),
      .MulStart(s_MulStart), .MulBusy(s_MulBusy), .MulDone(s_MulDone));

   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] m_rf [16];
   logic [31:0] m_pc;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl_idle();
      PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; RegSrc = 0; ALUSrcA = 0;
      ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0; ALUControl = 0; MulStart = 0;
   endtask

   function automatic logic [31:0] mk_instr(input int rn, input int rd, input int rm);
      return 32'hE000_0000 | (32'(rn) << 16) | (32'(rd) << 12) | 32'(rm);
   endfunction

   // {N,Z,C,V, result} from plain wide arithmetic on unsigned and signed views.
   function automatic logic [35:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint ua = longint'(a), ub = longint'(b);
      longint sa = longint'($signed(a)), sb = longint'($signed(b));
      longint s;
      logic [31:0] r;
      logic c = 1'b0, v = 1'b0;
      case (op)
         3'd0: begin r = a + b; c = (ua + ub) > 64'sd4294967295; s = sa + sb; v = (s > SMAX) || (s < SMIN); end
         3'd1: begin r = a - b; c = (ua >= ub); s = sa - sb; v = (s > SMAX) || (s < SMIN); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = b;
         default: r = '0;
      endcase
      return {r[31], r == 32'd0, c, v, r};
   endfunction

   task automatic set_instr(input logic [31:0] w);
      ctl_idle();
      ReadData = w; IRWrite = 1;
      tick();
      IRWrite = 0;
   endtask

   task automatic write_reg(input int r, input logic [31:0] v);
      set_instr(mk_instr(1, r, 2));
      ReadData = v;
      tick();
      ResultSrc = 2'b01; RegWrite = 1;
      tick();
      ctl_idle();
      m_rf[r] = v;
   endtask

   task automatic load_ab(input int ra, input int rb);
      set_instr(mk_instr(ra, 3, rb));
      tick();
   endtask

   task automatic alu_chk(input string tag, input logic [2:0] op, input logic [1:0] srcb,
                          input logic [31:0] a, input logic [31:0] b);
      logic [35:0] e;
      e = ref_alu(op, a, b);
      ALUSrcA = 2'b00; ALUSrcB = srcb; ALUControl = op; AdrSrc = 1;
      #1;
      chk({tag, "_flags"}, 32'(ALUFlags), 32'(e[35:32]));
      tick();
      chk({tag, "_res"}, Adr, e[31:0]);
   endtask

   task automatic fetch(input logic [31:0] w);
      ctl_idle();
      ReadData = w; IRWrite = 1; PCWrite = 1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      #1;
      chk("fetch_adr", Adr, m_pc);
      tick();
      m_pc = m_pc + 32'd4;
      chk("fetch_instr", Instr, w);
      chk("fetch_pc", Adr, m_pc);
      ctl_idle();
   endtask

   task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b);
      int busy_n = 0, done_n = 0, done_at = -1;
      logic [63:0] p;
      write_reg(1, a);
      write_reg(2, b);
      load_ab(1, 2);
      MulStart = 1;
      for (int i = 1; i <= 45; i++) begin
         tick();
         if (i == 1 || i == 11) MulStart = 0;
         if (i == 10) MulStart = 1;
         if (MulBusy) busy_n++;
         if (MulDone) begin done_n++; done_at = i; end
      end
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
      chk({tag, "_done_cycle"}, 32'(done_at), 32'd33);
      chk({tag, "_done_count"}, 32'(done_n), 32'd1);
      ResultSrc = 2'b11; RegWrite = 1;
      tick();
      RegWrite = 0; RegSrc = 2'b10;
      tick();
      p = 64'(a) * 64'(b);
      m_rf[3] = p[31:0];
      chk({tag, "_product"}, WriteData, m_rf[3]);
      ctl_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b, w, e;
      int busy_n, done_n, done_at;
      longint t;
      ctl_idle();
      reset = 1; ReadData = 0;
      s_reset = 1; s_PCWrite = 0; s_RegWrite = 0; s_IRWrite = 0; s_AdrSrc = 0; s_RegSrc = 0;
      s_ALUSrcA = 0; s_ALUSrcB = 0; s_ResultSrc = 0; s_ImmSrc = 0; s_ALUControl = 0;
      s_MulStart = 0; s_ReadData = 0;
      repeat (3) tick();
      chk("rst_adr", Adr, 32'd0);
      chk("rst_instr", Instr, 32'd0);
      chk("rst_busy", 32'(MulBusy), 32'd0);
      chk("rst_done", 32'(MulDone), 32'd0);
      chk("rst_flags", 32'(ALUFlags), 32'b0100);
      reset = 0;
      m_pc = 0;

      fetch(32'hE3A01005);
      repeat (3) fetch($urandom);

      // R15 reads through the file return Result (here PC+4)
      RegSrc = 2'b01; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      tick();
      alu_chk("r15_read", 3'd0, 2'b11, m_pc + 32'd4, 32'd0);
      ctl_idle();

      write_reg(1, 32'h7FFF_FFFF);
      load_ab(1, 1);
      alu_chk("add_ovf", 3'd0, 2'b01, m_rf[1], 32'd1);
      write_reg(4, 32'd5);
      write_reg(5, 32'd5);
      load_ab(4, 5);
      alu_chk("sub_eq", 3'd1, 2'b00, 32'd5, 32'd5);

      for (int k = 0; k < 6; k++) begin
         a = $urandom;
         b = (k == 2) ? a : $urandom;
         if (k == 3) begin a = 32'h8000_0000; b = 32'd1; end
         if (k == 4) begin a = 32'hFFFF_FFFF; b = 32'd1; end
         write_reg(1, a);
         write_reg(2, b);
         load_ab(1, 2);
         chk("wd_load", WriteData, b);
         for (int op = 0; op < 8; op++)
            alu_chk($sformatf("alu%0d", op), 3'(op), 2'b00, a, b);
      end

      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 2; j++) begin
            w = $urandom;
            if (j == 1) w[23] = 1'b1;
            set_instr(w);
            t = longint'(w[23:0]) * 4;
            if (w[23]) t = t - (64'sd1 <<< 26);
            case (k)
               0:       e = {24'd0, w[7:0]};
               1:       e = {20'd0, w[11:0]};
               2:       e = t[31:0];
               default: e = 32'd0;
            endcase
            ImmSrc = 2'(k);
            alu_chk($sformatf("imm%0d", k), 3'd5, 2'b01, 32'd0, e);
         end
      end

      mul_run("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      mul_run("mul_rand", $urandom, $urandom);
      mul_run("mul_7x6", 32'd7, 32'd6);

      // reset during RUN cycle 10: no done pulse, product register cleared
      MulStart = 1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 1) MulStart = 0;
      end
      chk("mid_busy_before", 32'(MulBusy), 32'd1);
      reset = 1;
      tick();
      chk("mid_busy_after", 32'(MulBusy), 32'd0);
      reset = 0;
      busy_n = 0; done_n = 0;
      repeat (40) begin
         tick();
         if (MulBusy) busy_n++;
         if (MulDone) done_n++;
      end
      chk("mid_no_done", 32'(done_n), 32'd0);
      chk("mid_no_busy", 32'(busy_n), 32'd0);
      ResultSrc = 2'b11; PCWrite = 1;
      tick();
      ctl_idle();
      chk("mid_mulout", Adr, 32'd0);

      // 16-bit, 8-register instance
      s_reset = 0;
      s_PCWrite = 1; s_ALUSrcA = 2'b01; s_ALUSrcB = 2'b10; s_ResultSrc = 2'b10;
      tick();
      chk("s_pc_step1", 32'(s_Adr), 32'd2);
      tick();
      chk("s_pc_step2", 32'(s_Adr), 32'd4);
      s_PCWrite = 0;
      s_ReadData = 16'h0002;
      tick();
      s_ResultSrc = 2'b01; s_RegWrite = 1;
      tick();
      s_RegWrite = 0; s_ReadData = 16'hFFFF;
      tick();
      s_RegSrc = 2'b01;
      tick();
      chk("s_wd", 32'(s_WriteData), 32'd2);
      s_MulStart = 1;
      busy_n = 0; done_n = 0; done_at = -1;
      for (int i = 1; i <= 25; i++) begin
         tick();
         if (i == 1) s_MulStart = 0;
         if (s_MulBusy) busy_n++;
         if (s_MulDone) begin done_n++; done_at = i; end
      end
      chk("s_busy_cycles", 32'(busy_n), 32'd17);
      chk("s_done_cycle", 32'(done_at), 32'd17);
      s_ResultSrc = 2'b11; s_PCWrite = 1;
      tick();
      s_PCWrite = 0;
      e = 32'h0000_FFFF * 32'd2;
      chk("s_mulout", 32'(s_Adr), {16'd0, e[15:0]});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
